regs_sb: RTL and testbench
==========================

// Module: regs_sb
// PURPOSE
//  Integer register file plus write-pending scoreboard: the responder to the decoder's
//  rs1_addr/rs2_addr requests. Returns operand data in the same cycle (combinational read).
//  Takes write-back from the end of the pipeline and tracks registers with an outstanding
//  write. Raises stall_o while a decoded instruction depends on a pending result.
//  Sits beside the id stage, which is combinational; all state lives here.
// PARAMETERS
//  REG_NUM   32  number of architectural registers (x0..x31)
//  DATA_W    32  register width in bits
//  ADDR_W    5   register address width; REG_NUM == 2**ADDR_W
// PORTS
//  clk             in   1       rising-edge clock
//  rst_n           in   1       asynchronous, active-low reset
//  rs1_addr_i      in   ADDR_W  source-1 address from decoder (0 = unused)
//  rs2_addr_i      in   ADDR_W  source-2 address from decoder (0 = unused)
//  rs1_data_o      out  DATA_W  source-1 data, same cycle
//  rs2_data_o      out  DATA_W  source-2 data, same cycle
//  issue_valid_i   in   1       decoder holds a valid instruction this cycle
//  rd_issue_i      in   ADDR_W  destination of the decoded instruction
//  rd_issue_wen_i  in   1       decoded instruction writes rd
//  wb_wen_i        in   1       write-back enable
//  wb_addr_i       in   ADDR_W  write-back address
//  wb_data_i       in   DATA_W  write-back data
//  flush_i         in   1       pipeline flush: clear all pending bits
//  stall_o         out  1       hold fetch/decode; instruction not accepted
// BEHAVIOUR
//  - Reset (rst_n=0, async): all registers = 0, all busy bits = 0; rs*_data_o then read 0.
//    stall_o is 0 while reset is held.
//  - x0: always reads 0; writes are ignored; it is never busy and never stalls.
//  - Read: rsN_data_o = (wb_wen_i && wb_addr_i==rsN_addr_i && rsN_addr_i!=0) ? wb_data_i
//    : regs[rsN_addr_i]. The write-back bypass gives zero-latency write-to-read forwarding.
//  - Write: regs[wb_addr_i] <= wb_data_i at posedge when wb_wen_i && wb_addr_i!=0.
//  - Hazard: hit(a) = a!=0 && busy[a] && !(wb_wen_i && wb_addr_i==a).
//    stall_o = issue_valid_i && (hit(rs1_addr_i) || hit(rs2_addr_i) ||
//    (rd_issue_wen_i && hit(rd_issue_i))). The rd check prevents WAW.
//    This leaves at most one outstanding write per register.
//  - Accept = issue_valid_i && !stall_o && !flush_i.
//  - Busy update at posedge, in priority order:
//    1. flush_i: all busy cleared. Issue is ignored. A write-back this cycle still writes regs.
//    2. Accept with rd_issue_wen_i && rd_issue_i!=0: busy[rd_issue_i] <= 1.
//       This wins over a same-cycle write-back clear of the same address.
//    3. wb_wen_i: busy[wb_addr_i] <= 0.
//  - A write-back to a non-busy register is legal: data is written, busy stays 0.
//  - Reset mid-operation: all pending state is lost. Late write-backs after reset
//    deassertion write data but do not affect busy.
//  - stall_o is purely combinational from inputs and busy; no registered latency.
// CONFIGURATION
//  REGS_SB_STALL_CNT_EN defined:
//    - Adds output stall_cnt_o [31:0]: counts cycles with stall_o=1.
//    - Saturates at 32'hFFFF_FFFF. Reset to 0 by rst_n. Not cleared by flush_i.
//  REGS_SB_STALL_CNT_EN undefined:
//    - The port and counter do not exist. All other behaviour is identical.
// TESTING
//  1. Reset with all regs written -> all reads 0, stall_o=0; x0 write of 5 -> x0 reads 0.
//  2. wb x3=32'h1234 with rs1_addr=3 in the same cycle -> rs1_data_o=32'h1234
//     (bypass) and the next cycle from the array.
//  3. Issue rd=5 accepted; next cycle rs2_addr=5 -> stall_o=1.
//     wb x5=7 that cycle -> stall_o=0, rs2_data_o=7.
//  4. Busy x6, then issue with rd=6, rs=0 -> stall_o=1 (WAW).
//     Same-cycle wb x6 + accepted issue rd=6 -> busy[6] stays 1.
//  5. Busy x7,x8 then flush_i=1 -> next cycle reading 7/8 gives stall_o=0.
//     A late wb x7=9 still writes 9.
//  6. With REGS_SB_STALL_CNT_EN: 4 stalled cycles -> stall_cnt_o=4.
//     Async rst_n pulse mid-cycle -> stall_cnt_o=0 and busy cleared immediately.

Source files
------------

// File: rtl/regs_sb.sv
// Integer register file with a write-pending scoreboard for the decode stage.
// Optional stall-cycle counter enabled by defining REGS_SB_STALL_CNT_EN.
module regs_sb #(
  parameter int unsigned REG_NUM = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] rs1_addr_i,
  input  logic [ADDR_W-1:0] rs2_addr_i,
  output logic [DATA_W-1:0] rs1_data_o,
  output logic [DATA_W-1:0] rs2_data_o,
  input  logic              issue_valid_i,
  input  logic [ADDR_W-1:0] rd_issue_i,
  input  logic              rd_issue_wen_i,
  input  logic              wb_wen_i,
  input  logic [ADDR_W-1:0] wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              flush_i,
`ifdef REGS_SB_STALL_CNT_EN
  output logic [31:0]       stall_cnt_o,
`endif
  output logic              stall_o
);

  localparam int unsigned CNT_W = 32;

  logic [DATA_W-1:0]  regs_q [REG_NUM];
  logic [REG_NUM-1:0] busy_q;
  logic [REG_NUM-1:0] busy_d;
  logic               accept;
  logic               hit_rs1;
  logic               hit_rs2;
  logic               hit_rd;

  // A register is a hazard if busy and not being written back this very cycle
  function automatic logic hit(input logic [ADDR_W-1:0] a,
                               input logic [REG_NUM-1:0] busy,
                               input logic wen,
                               input logic [ADDR_W-1:0] waddr);
    return (a != '0) && busy[a] && !(wen && (waddr == a));
  endfunction

  // Operand read with write-back bypass; x0 is hard-wired to zero
  always_comb begin
    rs1_data_o = regs_q[rs1_addr_i];
    rs2_data_o = regs_q[rs2_addr_i];
    if (wb_wen_i && (wb_addr_i == rs1_addr_i)) rs1_data_o = wb_data_i;
    if (wb_wen_i && (wb_addr_i == rs2_addr_i)) rs2_data_o = wb_data_i;
    if (rs1_addr_i == '0) rs1_data_o = '0;
    if (rs2_addr_i == '0) rs2_data_o = '0;
  end

  always_comb begin
    hit_rs1 = hit(rs1_addr_i, busy_q, wb_wen_i, wb_addr_i);
    hit_rs2 = hit(rs2_addr_i, busy_q, wb_wen_i, wb_addr_i);
    hit_rd  = rd_issue_wen_i && hit(rd_issue_i, busy_q, wb_wen_i, wb_addr_i);
    stall_o = issue_valid_i && (hit_rs1 || hit_rs2 || hit_rd);
    accept  = issue_valid_i && !stall_o && !flush_i;
  end

  // Busy update: flush beats issue, issue set beats write-back clear
  always_comb begin
    busy_d = busy_q;
    if (flush_i) begin
      busy_d = '0;
    end else begin
      if (wb_wen_i) busy_d[wb_addr_i] = 1'b0;
      if (accept && rd_issue_wen_i && (rd_issue_i != '0)) busy_d[rd_issue_i] = 1'b1;
    end
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < REG_NUM; i++) regs_q[i] <= '0;
    end else if (wb_wen_i && (wb_addr_i != '0)) begin
      regs_q[wb_addr_i] <= wb_data_i;
    end
  end

`ifdef REGS_SB_STALL_CNT_EN
  // Saturating count of stalled cycles; unaffected by flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_o <= '0;
    end else if (stall_o && (stall_cnt_o != {CNT_W{1'b1}})) begin
      stall_cnt_o <= stall_cnt_o + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_regs_sb.sv
// Directed bench for regs_sb: sequential vector table plus reset and counter sequences.
module tb_regs_sb;

  logic        clk;
  logic        rst_n;
  logic [4:0]  rs1_addr_i, rs2_addr_i, rd_issue_i, wb_addr_i;
  logic [31:0] rs1_data_o, rs2_data_o, wb_data_i;
  logic        issue_valid_i, rd_issue_wen_i, wb_wen_i, flush_i, stall_o;
`ifdef REGS_SB_STALL_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_pass;
  int n_total;

  regs_sb dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .rs1_addr_i     (rs1_addr_i),
    .rs2_addr_i     (rs2_addr_i),
    .rs1_data_o     (rs1_data_o),
    .rs2_data_o     (rs2_data_o),
    .issue_valid_i  (issue_valid_i),
    .rd_issue_i     (rd_issue_i),
    .rd_issue_wen_i (rd_issue_wen_i),
    .wb_wen_i       (wb_wen_i),
    .wb_addr_i      (wb_addr_i),
    .wb_data_i      (wb_data_i),
    .flush_i        (flush_i),
`ifdef REGS_SB_STALL_CNT_EN
    .stall_cnt_o    (stall_cnt_o),
`endif
    .stall_o        (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic        iv;
    logic [4:0]  rd;
    logic        rdw;
    logic        wbw;
    logic [4:0]  wba;
    logic [31:0] wbd;
    logic        fl;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        es;
  } vec_t;

  vec_t vecs[26];

  function automatic vec_t mk(input logic [4:0] rs1, input logic [4:0] rs2, input logic iv,
                              input logic [4:0] rd, input logic rdw, input logic wbw,
                              input logic [4:0] wba, input logic [31:0] wbd, input logic fl,
                              input logic [31:0] e1, input logic [31:0] e2, input logic es);
    vec_t v;
    v.rs1 = rs1; v.rs2 = rs2; v.iv = iv; v.rd = rd; v.rdw = rdw; v.wbw = wbw;
    v.wba = wba; v.wbd = wbd; v.fl = fl; v.e1 = e1; v.e2 = e2; v.es = es;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
    else n_pass++;
  endtask

  // Drive one cycle's inputs just after the falling edge
  task automatic drive(input vec_t v);
    @(negedge clk);
    rs1_addr_i = v.rs1; rs2_addr_i = v.rs2; issue_valid_i = v.iv;
    rd_issue_i = v.rd; rd_issue_wen_i = v.rdw; wb_wen_i = v.wbw;
    wb_addr_i = v.wba; wb_data_i = v.wbd; flush_i = v.fl;
    #1;
  endtask

  task automatic idle();
    drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
  endtask

  initial begin
    vec_t v;
    n_pass = 0;
    n_total = 0;
    rst_n = 1'b0;
    rs1_addr_i = '0; rs2_addr_i = '0; issue_valid_i = 1'b0; rd_issue_i = '0;
    rd_issue_wen_i = 1'b0; wb_wen_i = 1'b0; wb_addr_i = '0; wb_data_i = '0; flush_i = 1'b0;

    // During reset: reads zero, no stall even with a valid issue
    drive(mk(5, 9, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_stall", 32'(stall_o), 32'd0);
    chk("rst_rs1", rs1_data_o, 32'd0);
    drive(mk(5, 9, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0));
    chk("rst_stall2", 32'(stall_o), 32'd0);
    rst_n = 1'b1;

    // Fill every register, then spot-check
    for (int i = 1; i < 32; i++) drive(mk(0, 0, 0, 0, 0, 1, 5'(i), 32'(i) * 32'h11, 0, 0, 0, 0));
    idle();
    drive(mk(31, 17, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("fill_x31", rs1_data_o, 32'h0000_020F);
    chk("fill_x17", rs2_data_o, 32'h0000_0121);

    // Async reset pulse between edges wipes everything
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 32; i++) begin
      drive(mk(5'(i), 5'(31 - i), 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
      if (i % 4 == 0) begin
        chk($sformatf("clr_rs1_x%0d", i), rs1_data_o, 32'd0);
        chk($sformatf("clr_rs2_x%0d", 31 - i), rs2_data_o, 32'd0);
      end
    end

    //            rs1 rs2 iv rd rdw wbw wba wbd           fl e1            e2           es
    vecs[0]  = mk(0,  0,  0, 0, 0,  1,  0,  32'd5,        0, 32'd0,        32'd0,       0);
    vecs[1]  = mk(0,  0,  0, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[2]  = mk(3,  4,  0, 0, 0,  1,  3,  32'h1234,     0, 32'h1234,     32'd0,       0);
    vecs[3]  = mk(3,  0,  0, 0, 0,  0,  0,  32'd0,        0, 32'h1234,     32'd0,       0);
    vecs[4]  = mk(3,  0,  1, 5, 1,  0,  0,  32'd0,        0, 32'h1234,     32'd0,       0);
    vecs[5]  = mk(0,  5,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       1);
    vecs[6]  = mk(0,  5,  1, 0, 0,  1,  5,  32'd7,        0, 32'd0,        32'd7,       0);
    vecs[7]  = mk(0,  5,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd7,       0);
    vecs[8]  = mk(0,  0,  1, 6, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[9]  = mk(0,  0,  1, 6, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       1);
    vecs[10] = mk(6,  0,  1, 6, 1,  1,  6,  32'h66,       0, 32'h66,       32'd0,       0);
    vecs[11] = mk(6,  0,  1, 0, 0,  0,  0,  32'd0,        0, 32'h66,       32'd0,       1);
    vecs[12] = mk(0,  0,  1, 7, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[13] = mk(0,  0,  1, 8, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[14] = mk(7,  8,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       1);
    vecs[15] = mk(7,  0,  1, 0, 0,  0,  0,  32'd0,        1, 32'd0,        32'd0,       1);
    vecs[16] = mk(7,  8,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[17] = mk(7,  0,  0, 0, 0,  1,  7,  32'd9,        0, 32'd9,        32'd0,       0);
    vecs[18] = mk(7,  6,  1, 0, 0,  0,  0,  32'd0,        0, 32'd9,        32'h66,      0);
    vecs[19] = mk(0,  0,  1, 0, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[20] = mk(0,  0,  1, 0, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[21] = mk(0,  0,  1, 9, 1,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[22] = mk(9,  0,  0, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);
    vecs[23] = mk(0,  9,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       1);
    vecs[24] = mk(0,  0,  1, 10, 1, 0,  0,  32'd0,        1, 32'd0,        32'd0,       0);
    vecs[25] = mk(10, 9,  1, 0, 0,  0,  0,  32'd0,        0, 32'd0,        32'd0,       0);

    for (int i = 0; i < 26; i++) begin
      drive(vecs[i]);
      chk($sformatf("v%0d_rs1", i), rs1_data_o, vecs[i].e1);
      chk($sformatf("v%0d_rs2", i), rs2_data_o, vecs[i].e2);
      chk($sformatf("v%0d_stall", i), 32'(stall_o), 32'(vecs[i].es));
    end

    // Mid-cycle reset drops pending state; a late write-back still lands
    drive(mk(0, 0, 1, 11, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("pre_rst_busy", 32'(stall_o), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", 32'(stall_o), 32'd0);
    chk("mid_rst_data", rs2_data_o, 32'd0);
    rst_n = 1'b1;
    drive(mk(11, 0, 0, 0, 0, 1, 11, 32'h55, 0, 0, 0, 0));
    drive(mk(11, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    chk("late_wb_data", rs1_data_o, 32'h55);
    chk("late_wb_stall", 32'(stall_o), 32'd0);

`ifdef REGS_SB_STALL_CNT_EN
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    chk("cnt_rst", stall_cnt_o, 32'd0);
    drive(mk(0, 0, 1, 12, 1, 0, 0, 0, 0, 0, 0, 0));
    for (int i = 0; i < 4; i++) drive(mk(12, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    idle();
    chk("cnt_four", stall_cnt_o, 32'd4);
    drive(mk(12, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    idle();
    chk("cnt_flush", stall_cnt_o, 32'd5);
    drive(mk(0, 0, 1, 13, 1, 0, 0, 0, 0, 0, 0, 0));
    drive(mk(13, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    rst_n = 1'b0;
    #1;
    chk("cnt_async_clr", stall_cnt_o, 32'd0);
    chk("cnt_async_stall", 32'(stall_o), 32'd0);
    rst_n = 1'b1;
`endif

    idle();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
